// File: rtl/crop_window_ctrl_if.sv
// Signal bundle between the two window requesters, the frame timing source
// and the crop window controller.
interface crop_window_ctrl_if;
  logic        iFRAME_END;
  logic        iREQ0;
  logic [63:0] iWIN0;
  logic        oACK0;
  logic        oERR0;
  logic        iREQ1;
  logic [63:0] iWIN1;
  logic        oACK1;
  logic        oERR1;
  logic [15:0] oXSTART;
  logic [15:0] oXEND;
  logic [15:0] oYSTART;
  logic [15:0] oYEND;
  logic        oUPDATE;
  logic        oBUSY;

  modport slave (
    input  iFRAME_END, iREQ0, iWIN0, iREQ1, iWIN1,
    output oACK0, oERR0, oACK1, oERR1,
    output oXSTART, oXEND, oYSTART, oYEND, oUPDATE, oBUSY
  );

  modport master (
    output iFRAME_END, iREQ0, iWIN0, iREQ1, iWIN1,
    input  oACK0, oERR0, oACK1, oERR1,
    input  oXSTART, oXEND, oYSTART, oYEND, oUPDATE, oBUSY
  );
endinterface

// File: rtl/crop_window_ctrl.sv
// Crop window controller: two round-robin requesters submit windows
// {XSTART, XEND, YSTART, YEND}; a window is validated, then applied to the
// registered outputs only on a frame boundary so it never changes mid-frame.
module crop_window_ctrl #(
  parameter int unsigned H_MAX = 640,
  parameter int unsigned V_MAX = 480
) (
  input  logic iCLK,
  input  logic iRST,
  crop_window_ctrl_if.slave bus
);

  localparam logic [15:0] LP_HLAST = 16'(H_MAX - 1);
  localparam logic [15:0] LP_VLAST = 16'(V_MAX - 1);

  typedef enum logic [1:0] {IDLE, CHECK, WAIT_FRAME, APPLY} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [63:0] r_pend;
  logic        r_grant;   // 0: requester 0, 1: requester 1
  logic        r_prio;    // requester favoured on a simultaneous request
  logic [15:0] r_xs, r_xe, r_ys, r_ye;
  logic        r_upd, r_ack0, r_ack1, r_err0, r_err1;

  logic        w_capture, w_gnt, w_load, w_reject, w_valid;
  logic [15:0] w_xs, w_xe, w_ys, w_ye;

  assign w_xs    = r_pend[63:48];
  assign w_xe    = r_pend[47:32];
  assign w_ys    = r_pend[31:16];
  assign w_ye    = r_pend[15:0];
  assign w_valid = (w_xs <= w_xe) && (w_xe <= LP_HLAST) &&
                   (w_ys <= w_ye) && (w_ye <= LP_VLAST);

  // Next-state and transaction decode; the error cycle is spent in IDLE, so
  // requests are masked there to let the rejected requester drop iREQ first.
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_gnt     = r_prio;
    w_load    = 1'b0;
    w_reject  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!(r_err0 || r_err1) && (bus.iREQ0 || bus.iREQ1)) begin
          w_capture = 1'b1;
          w_gnt     = (bus.iREQ0 && bus.iREQ1) ? r_prio : bus.iREQ1;
          w_next    = CHECK;
        end
      end
      CHECK: begin
        if (w_valid) begin
          w_next = WAIT_FRAME;
        end else begin
          w_reject = 1'b1;
          w_next   = IDLE;
        end
      end
      WAIT_FRAME: begin
        if (bus.iFRAME_END) begin
          w_load = 1'b1;
          w_next = APPLY;
        end
      end
      APPLY:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State, pending window, arbitration and registered outputs.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state <= IDLE;
      r_pend  <= '0;
      r_grant <= 1'b0;
      r_prio  <= 1'b0;
      r_xs    <= '0;
      r_xe    <= LP_HLAST;
      r_ys    <= '0;
      r_ye    <= LP_VLAST;
      r_upd   <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_err0  <= 1'b0;
      r_err1  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_capture) begin
        r_pend  <= w_gnt ? bus.iWIN1 : bus.iWIN0;
        r_grant <= w_gnt;
        r_prio  <= ~w_gnt;
      end
      if (w_load) begin
        r_xs <= w_xs;
        r_xe <= w_xe;
        r_ys <= w_ys;
        r_ye <= w_ye;
      end
      r_upd  <= w_load;
      r_ack0 <= w_load & ~r_grant;
      r_ack1 <= w_load &  r_grant;
      r_err0 <= w_reject & ~r_grant;
      r_err1 <= w_reject &  r_grant;
    end
  end

  assign bus.oXSTART = r_xs;
  assign bus.oXEND   = r_xe;
  assign bus.oYSTART = r_ys;
  assign bus.oYEND   = r_ye;
  assign bus.oUPDATE = r_upd;
  assign bus.oACK0   = r_ack0;
  assign bus.oACK1   = r_ack1;
  assign bus.oERR0   = r_err0;
  assign bus.oERR1   = r_err1;
  assign bus.oBUSY   = (r_state != IDLE);

endmodule
